// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit: control-word layout,
// funct3 access sizes, writeback sources, fault causes and FSM states.
package mem_stage_pkg;

  localparam int CTRL_F3_LSB     = 0;
  localparam int CTRL_PC_SRC     = 3;
  localparam int CTRL_WB_SRC_LSB = 4;
  localparam int CTRL_MEM_WE     = 6;
  localparam int CTRL_MEM_RE     = 7;
  localparam int CTRL_RF_WB      = 8;
  localparam int CTRL_BR_TAKEN   = 9;
  localparam int CTRL_W          = 10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {WB_ALU, WB_LOAD, WB_PC4, WB_ZERO} wb_src_e;
  typedef enum logic [1:0] {CAUSE_NONE, CAUSE_MISALIGN, CAUSE_BUS_ERR, CAUSE_TIMEOUT} fault_cause_e;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_e;

  function automatic logic [31:0] wb_select(input logic [1:0] src, input logic [31:0] alu,
                                            input logic [31:0] ld, input logic [31:0] pc4);
    case (src)
      WB_ALU:  return alu;
      WB_LOAD: return ld;
      WB_PC4:  return pc4;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      F3_SB[1:0]: return 4'b0001 << off;
      F3_SH[1:0]: return 4'b0011 << off;
      default:    return 4'b1111;
    endcase
  endfunction

  // Store data is replicated into every lane so the strobes alone pick the bytes.
  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      F3_SB[1:0]: return {4{d[7:0]}};
      F3_SH[1:0]: return {2{d[15:0]}};
      default:    return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_lsu_load_align.sv
// Load lane selection and sign/zero extension for the MEM stage (purely combinational).
module load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{byte_off, 3'b000} +: 8];
  assign lane_h = rdata[{byte_off[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data = rdata;
    case (funct3)
      F3_LB:   data = {{24{lane_b[7]}}, lane_b};
      F3_LBU:  data = {24'd0, lane_b};
      F3_LH:   data = {{16{lane_h[15]}}, lane_h};
      F3_LHU:  data = {16'd0, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: EX handshake in, data-bus request/response, WB handshake out.
// Define MEM_STAGE_MISALIGN_TRAP_EN to fault misaligned accesses instead of force-aligning them.
module mem_stage_lsu
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int CW_W        = 16,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  input  logic [31:0]       pc_plus_4,
  input  logic [31:0]       alu_result,
  input  logic [CW_W-1:0]   ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       wb_data,
  output logic [3:0]        ctrl_out,
  output logic              dbus_req,
  output logic              dbus_we,
  output logic [ADDR_W-1:0] dbus_addr,
  output logic [31:0]       dbus_wdata,
  output logic [3:0]        dbus_strb,
  input  logic              dbus_gnt,
  input  logic              dbus_rvalid,
  input  logic              dbus_err,
  input  logic [31:0]       dbus_rdata,
  output logic              fault,
  output logic [1:0]        fault_cause
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [2:0]         f3_q;
  logic               we_q, rf_q, pcsm_q;
  logic [1:0]         src_q;
  logic [31:0]        alu_q, pc4_q;

  logic [2:0]         in_f3;
  logic [1:0]         in_src, in_off;
  logic               in_we, in_is_mem, in_rf, in_pcsm, in_mis;
  logic [ADDR_W-1:0]  in_addr_al;
  logic               bus_done, ld_ok;
  fault_cause_e       bus_cause;
  logic [31:0]        ld_data;
  logic               ctrl_unused;

  assign in_f3       = ctrl[CTRL_F3_LSB +: 3];
  assign in_src      = ctrl[CTRL_WB_SRC_LSB +: 2];
  assign in_we       = ctrl[CTRL_MEM_WE];
  assign in_is_mem   = ctrl[CTRL_MEM_RE] | ctrl[CTRL_MEM_WE];
  assign in_rf       = ctrl[CTRL_RF_WB];
  assign in_pcsm     = ctrl[CTRL_BR_TAKEN] & ctrl[CTRL_PC_SRC];
  assign ctrl_unused = ^ctrl[CW_W-1:CTRL_W];

  // Natural alignment of the offset; without the trap this is the address actually issued.
  always_comb begin
    in_off = addr[1:0];
    in_mis = 1'b0;
    case (in_f3[1:0])
      2'b00: in_off = addr[1:0];
      2'b01: begin
        in_mis = addr[0];
        in_off = {addr[1], 1'b0};
      end
      default: begin
        in_mis = |addr[1:0];
        in_off = 2'b00;
      end
    endcase
    in_addr_al = {addr[ADDR_W-1:2], in_off};
  end

  // Bus completion: error beats data, a load may finish on the grant cycle itself.
  always_comb begin
    bus_done  = 1'b0;
    bus_cause = CAUSE_NONE;
    ld_ok     = 1'b0;
    case (state)
      S_REQ: if (dbus_gnt) begin
        if (dbus_err) begin
          bus_done  = 1'b1;
          bus_cause = CAUSE_BUS_ERR;
        end else if (we_q) begin
          bus_done = 1'b1;
        end else if (dbus_rvalid) begin
          bus_done = 1'b1;
          ld_ok    = 1'b1;
        end
      end
      S_WAIT: if (dbus_rvalid) begin
        bus_done = 1'b1;
        if (dbus_err) bus_cause = CAUSE_BUS_ERR;
        else          ld_ok     = 1'b1;
      end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
        bus_done  = 1'b1;
        bus_cause = CAUSE_TIMEOUT;
      end
      default: bus_done = 1'b0;
    endcase
  end

  load_align u_load_align (
    .rdata    (dbus_rdata),
    .byte_off (dbus_addr[1:0]),
    .funct3   (f3_q),
    .data     (ld_data)
  );

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      in_ready    <= 1'b1;
      out_valid   <= 1'b0;
      wb_data     <= '0;
      ctrl_out    <= '0;
      fault       <= 1'b0;
      fault_cause <= '0;
      dbus_req    <= 1'b0;
      dbus_we     <= 1'b0;
      dbus_addr   <= '0;
      dbus_wdata  <= '0;
      dbus_strb   <= '0;
      f3_q        <= '0;
      we_q        <= 1'b0;
      rf_q        <= 1'b0;
      pcsm_q      <= 1'b0;
      src_q       <= '0;
      alu_q       <= '0;
      pc4_q       <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          in_ready <= 1'b0;
          f3_q     <= in_f3;
          we_q     <= in_we;
          rf_q     <= in_rf;
          src_q    <= in_src;
          pcsm_q   <= in_pcsm;
          alu_q    <= alu_result;
          pc4_q    <= pc_plus_4;
          if (!in_is_mem || (TRAP_EN && in_mis)) begin
            state     <= S_DONE;
            out_valid <= 1'b1;
            wb_data   <= wb_select(in_src, alu_result, 32'd0, pc_plus_4);
            ctrl_out  <= {in_rf & !in_is_mem, in_src, in_pcsm};
            if (in_is_mem) begin
              fault       <= 1'b1;
              fault_cause <= CAUSE_MISALIGN;
            end
          end else begin
            state      <= S_REQ;
            dbus_req   <= 1'b1;
            dbus_we    <= in_we;
            dbus_addr  <= in_addr_al;
            dbus_strb  <= store_strb(in_f3, in_off);
            dbus_wdata <= store_wdata(in_f3, store_data);
          end
        end
        S_REQ, S_WAIT: begin
          if (bus_done) begin
            state       <= S_DONE;
            dbus_req    <= 1'b0;
            out_valid   <= 1'b1;
            wb_data     <= wb_select(src_q, alu_q, ld_ok ? ld_data : 32'd0, pc4_q);
            ctrl_out    <= {rf_q & (bus_cause == CAUSE_NONE), src_q, pcsm_q};
            fault       <= (bus_cause != CAUSE_NONE);
            fault_cause <= bus_cause;
          end else if (state == S_REQ) begin
            if (dbus_gnt) begin
              state    <= S_WAIT;
              dbus_req <= 1'b0;
              cnt      <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: if (out_ready) begin
          state       <= S_IDLE;
          in_ready    <= 1'b1;
          out_valid   <= 1'b0;
          wb_data     <= '0;
          ctrl_out    <= '0;
          fault       <= 1'b0;
          fault_cause <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: directed corner cases then randomized traffic
// against a byte-level reference model; a bus responder and a WB monitor run independently.
module tb_mem_stage_lsu;

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk, rst;
  logic        in_valid, in_ready;
  logic [31:0] addr, store_data, pc_plus_4, alu_result;
  logic [15:0] ctrl;
  logic        out_valid, out_ready;
  logic [31:0] wb_data;
  logic [3:0]  ctrl_out;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_strb;
  logic        dbus_gnt, dbus_rvalid, dbus_err;
  logic [31:0] dbus_rdata;
  logic        fault;
  logic [1:0]  fault_cause;

  mem_stage_lsu #(.ADDR_W(32), .CW_W(16), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .addr(addr), .store_data(store_data), .pc_plus_4(pc_plus_4), .alu_result(alu_result),
    .ctrl(ctrl),
    .out_valid(out_valid), .out_ready(out_ready),
    .wb_data(wb_data), .ctrl_out(ctrl_out),
    .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
    .dbus_wdata(dbus_wdata), .dbus_strb(dbus_strb),
    .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid), .dbus_err(dbus_err), .dbus_rdata(dbus_rdata),
    .fault(fault), .fault_cause(fault_cause)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a, sd, alu, pc4;
    logic [2:0]  f3;
    logic [1:0]  src;
    logic        re, we, rf, bt, pc;
  } txn_t;

  typedef struct {
    int          gnt_dly, rv_dly;
    logic [31:0] rdata;
    bit          err_gnt, err_rv, no_rv;
    logic [31:0] b_addr, b_wdata;
    logic [3:0]  b_strb;
    logic        b_we;
  } plan_t;

  typedef struct {
    logic [31:0] wb;
    logic [3:0]  cw;
    logic [2:0]  flt;
  } exp_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    force_stall = 1'b0;
  bit    force_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  endtask

  task automatic abort(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got no response expected DUT progress", name);
    finish_run();
  endtask

  function automatic txn_t mk_txn(input logic [2:0] f3, input bit re, input bit we,
                                  input logic [1:0] src, input logic [31:0] a,
                                  input logic [31:0] sd, input logic [31:0] alu);
    txn_t t;
    t.f3 = f3; t.re = re; t.we = we; t.src = src; t.a = a; t.sd = sd; t.alu = alu;
    t.pc4 = 32'h0000_1004; t.rf = 1'b1; t.bt = 1'b1; t.pc = 1'b1;
    return t;
  endfunction

  function automatic plan_t mk_plan(input int g, input int r, input logic [31:0] rd,
                                    input bit eg, input bit er, input bit nr);
    plan_t p;
    p.gnt_dly = g; p.rv_dly = r; p.rdata = rd; p.err_gnt = eg; p.err_rv = er; p.no_rv = nr;
    p.b_addr = '0; p.b_wdata = '0; p.b_strb = '0; p.b_we = 1'b0;
    return p;
  endfunction

  // Reference model: byte-level view of the access, expected WB and bus values.
  task automatic issue(input txn_t t, input plan_t p);
    int          n, size, off;
    logic [31:0] eff, v, mask, wd;
    logic [1:0]  cause;
    bit          bus;
    exp_t        e;
    size  = 1 << t.f3[1:0];
    eff   = t.a - (t.a % size);
    off   = int'(eff % 4);
    cause = 2'd0;
    v     = 32'd0;
    bus   = t.re || t.we;
    if (bus && TRAP && (t.a % size) != 0) begin
      cause = 2'd1;
      bus   = 1'b0;
    end
    if (bus) begin
      for (int lane = 0; lane < 4; lane++) wd[8*lane +: 8] = t.sd[8*(lane % size) +: 8];
      p.b_addr = eff; p.b_we = t.we; p.b_wdata = wd;
      p.b_strb = 4'(((1 << size) - 1) << off);
      if (p.err_gnt)       cause = 2'd2;
      else if (t.we)       cause = 2'd0;
      else if (p.err_rv)   cause = 2'd2;
      else if (p.no_rv)    cause = 2'd3;
      else begin
        v = p.rdata >> (8 * off);
        if (size < 4) begin
          mask = (32'd1 << (8 * size)) - 32'd1;
          v = v & mask;
          if (!t.f3[2] && v[8*size-1]) v = v | ~mask;
        end
      end
    end
    case (t.src)
      2'd0: e.wb = t.alu;
      2'd1: e.wb = v;
      2'd2: e.wb = t.pc4;
      default: e.wb = 32'd0;
    endcase
    e.cw  = {t.rf && cause == 2'd0, t.src, t.bt && t.pc};
    e.flt = {cause != 2'd0, cause};

    n = 0;
    while (!in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) abort("in_ready_wait");
    end
    in_valid   = 1'b1;
    addr       = t.a;
    store_data = t.sd;
    alu_result = t.alu;
    pc_plus_4  = t.pc4;
    ctrl       = {6'($urandom), t.bt, t.rf, t.re, t.we, t.src, t.pc, t.f3};
    exp_q.push_back(e);
    if (bus) plan_q.push_back(p);
    @(negedge clk);
    in_valid = 1'b0;
    addr     = $urandom;
    if (!bus) check("accept_to_out_valid", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 || !in_ready) begin
      @(negedge clk);
      n++;
      if (n > 200) abort("drain");
    end
  endtask

  // Data-bus responder: follows the plan pushed for each request.
  initial begin
    plan_t p;
    dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0; dbus_rdata = 0;
    forever begin
      @(negedge clk);
      if (rst && dbus_req) begin
        if (plan_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dbus_req: got addr 0x%08h expected no request", dbus_addr);
          p = mk_plan(0, 0, 0, 1'b1, 1'b0, 1'b0);
          p.b_addr = dbus_addr; p.b_we = dbus_we; p.b_strb = dbus_strb; p.b_wdata = dbus_wdata;
        end else begin
          p = plan_q.pop_front();
        end
        check("dbus_addr", dbus_addr, p.b_addr);
        check("dbus_we", dbus_we, p.b_we);
        if (p.b_we) begin
          check("dbus_strb", dbus_strb, p.b_strb);
          check("dbus_wdata", dbus_wdata, p.b_wdata);
        end
        repeat (p.gnt_dly) @(negedge clk);
        check("dbus_req_held", dbus_req, 1);
        check("dbus_addr_stable", dbus_addr, p.b_addr);
        dbus_gnt = 1'b1;
        dbus_err = p.err_gnt;
        if (!p.b_we && !p.err_gnt && !p.no_rv && p.rv_dly == 0) begin
          dbus_rvalid = 1'b1;
          dbus_rdata  = p.rdata;
          dbus_err    = p.err_rv;
        end
        @(negedge clk);
        dbus_gnt = 0; dbus_rvalid = 0; dbus_err = 0; dbus_rdata = $urandom;
        if (!p.b_we && !p.err_gnt && !p.no_rv && p.rv_dly > 0) begin
          repeat (p.rv_dly - 1) @(negedge clk);
          dbus_rvalid = 1'b1;
          dbus_rdata  = p.rdata;
          dbus_err    = p.err_rv;
          @(negedge clk);
          dbus_rvalid = 0; dbus_err = 0; dbus_rdata = $urandom;
        end
      end
    end
  end

  // WB monitor: compares every cycle out_valid is high, so stalls also check stability.
  initial begin
    exp_t e;
    out_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: got wb_data 0x%08h expected no output", wb_data);
        end else begin
          e = exp_q[0];
          check("wb_data", wb_data, e.wb);
          check("ctrl_out", ctrl_out, e.cw);
          check("fault_cause", {fault, fault_cause}, e.flt);
        end
      end else begin
        check("fault_idle", {fault, fault_cause}, 0);
      end
      out_ready = force_stall ? 1'b0 : (force_ready ? 1'b1 : ($urandom_range(0, 3) != 0));
      if (out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end
  end

  initial begin
    #500000;
    abort("global_watchdog");
  end

  initial begin
    txn_t t;
    plan_t p;
    int kind;
    rst = 1'b0; in_valid = 0; addr = 0; store_data = 0; pc_plus_4 = 0; alu_result = 0; ctrl = 0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_dbus_req", dbus_req, 0);
    check("rst_dbus_we", dbus_we, 0);
    check("rst_dbus_addr", dbus_addr, 0);
    check("rst_dbus_strb", dbus_strb, 0);
    check("rst_dbus_wdata", dbus_wdata, 0);
    check("rst_wb_data", wb_data, 0);
    check("rst_ctrl_out", ctrl_out, 0);
    rst = 1'b1;
    @(negedge clk);

    force_ready = 1'b1;
    issue(mk_txn(3'b000, 0, 0, 2'd0, 32'h0, 32'h0, 32'h1234), mk_plan(0, 0, 0, 0, 0, 0));
    drain();
    force_ready = 1'b0;
    issue(mk_txn(3'b000, 1, 0, 2'd1, 32'h103, 32'h0, 32'h55), mk_plan(2, 3, 32'h80FF_0000, 0, 0, 0));
    issue(mk_txn(3'b001, 0, 1, 2'd0, 32'h102, 32'h0000_ABCD, 32'h66), mk_plan(1, 0, 0, 0, 0, 0));
    issue(mk_txn(3'b010, 1, 0, 2'd1, 32'h200, 32'h0, 32'h77), mk_plan(0, 0, 0, 0, 0, 1));
    issue(mk_txn(3'b010, 1, 0, 2'd1, 32'h101, 32'h0, 32'h88), mk_plan(0, 1, 32'hDEAD_BEEF, 0, 0, 0));
    issue(mk_txn(3'b000, 0, 1, 2'd2, 32'h3, 32'hA5, 32'h99), mk_plan(1, 0, 0, 1, 0, 0));
    issue(mk_txn(3'b101, 1, 0, 2'd1, 32'h6, 32'h0, 32'hAA), mk_plan(0, 2, 32'h1234_5678, 0, 1, 0));
    issue(mk_txn(3'b001, 1, 0, 2'd1, 32'h302, 32'h0, 32'hBB), mk_plan(0, 0, 32'h8001_7F00, 0, 0, 0));
    drain();

    force_stall = 1'b1;
    issue(mk_txn(3'b000, 0, 0, 2'd2, 32'h0, 32'h0, 32'hCC), mk_plan(0, 0, 0, 0, 0, 0));
    repeat (4) @(negedge clk);
    force_stall = 1'b0;
    drain();

    issue(mk_txn(3'b010, 1, 0, 2'd1, 32'h400, 32'h0, 32'hDD), mk_plan(0, 0, 0, 0, 0, 1));
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("rst_mid_dbus_req", dbus_req, 0);
    check("rst_mid_in_ready", in_ready, 1);
    check("rst_mid_out_valid", out_valid, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 200; i++) begin
      kind = $urandom_range(0, 9);
      t = mk_txn(3'($urandom), 0, 0, 2'($urandom), $urandom, $urandom, $urandom);
      t.pc4 = $urandom; t.rf = 1'($urandom); t.bt = 1'($urandom); t.pc = 1'($urandom);
      if (kind >= 4 && kind < 7) begin
        t.re = 1'b1;
        case ($urandom_range(0, 4))
          0: t.f3 = 3'b000;
          1: t.f3 = 3'b001;
          2: t.f3 = 3'b010;
          3: t.f3 = 3'b100;
          default: t.f3 = 3'b101;
        endcase
      end else if (kind >= 7) begin
        t.we = 1'b1;
        t.f3 = 3'($urandom_range(0, 2));
      end
      p = mk_plan($urandom_range(0, 3), $urandom_range(0, 4), $urandom, 1'b0, 1'b0, 1'b0);
      p.err_gnt = ($urandom_range(0, 9) == 0);
      p.err_rv  = t.re && !p.err_gnt && ($urandom_range(0, 9) == 0);
      p.no_rv   = t.re && !p.err_gnt && !p.err_rv && ($urandom_range(0, 14) == 0);
      issue(t, p);
    end
    drain();
    finish_run();
  end

endmodule
